spi_reg_bus_bridge: RTL and testbench
=====================================

Name: spi_reg_bus_bridge

Overview:
- Sits directly downstream of the SPI register slave in the test harness.
- Turns each decoded SPI transaction (address, R/W, width, write data) into one TinyQV-style peripheral bus access, and holds that access until the peripheral acknowledges.
- Returns read data to the SPI slave, with a valid strobe, so the slave can shift it out on MISO.
- A watchdog ends accesses the peripheral never acknowledges and records the fault in a sticky error flag.

Parameters:
- ADDR_W, 6, width of register address from SPI slave and to the bus
- REG_W, 32, data width; must be 32
- TIMEOUT, 255, cycles to wait for bus_data_ready before aborting; 1..255

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- ena  in  1  clock enable; when low, all state, counters and outputs hold
- reg_addr  in  ADDR_W  transaction address from SPI slave
- reg_rw  in  1  1=write, 0=read
- txn_width  in  2  00 byte, 01 half, 10 word, 11 invalid
- reg_data_o  in  REG_W  write data from SPI slave
- reg_data_o_dv  in  1  one-cycle write-request strobe
- reg_addr_v  in  1  read request; level, held high until reg_data_i_dv seen
- reg_data_i  out  REG_W  read data to SPI slave
- reg_data_i_dv  out  1  one-cycle read-data-valid strobe
- bus_addr  out  ADDR_W  peripheral address
- bus_data_out  out  REG_W  peripheral write data, low-aligned
- bus_data_write_n  out  2  11 idle, else width of write
- bus_data_read_n  out  2  11 idle, else width of read
- bus_data_in  in  REG_W  peripheral read data
- bus_data_ready  in  1  peripheral acknowledge
- err_timeout  out  1  sticky watchdog-abort flag
- err_clear  in  1  clears err_timeout

Behaviour:
- Reset values (rst=1 at a posedge): state=IDLE, reg_data_i=0, reg_data_i_dv=0, bus_addr=0, bus_data_out=0, bus_data_write_n=11, bus_data_read_n=11, err_timeout=0, watchdog count=0.
- Reset mid-access: bus strobes return to 11 on the next edge; no dv is emitted.
- States: IDLE, WRITE, READ, RESP, DRAIN.
- IDLE, write request (reg_data_o_dv=1):
  - Latch reg_addr, reg_data_o and txn_width.
  - txn_width=11: stay in IDLE and drop the request.
  - Otherwise go to WRITE.
- IDLE, read request (reg_addr_v=1, reg_rw=0):
  - Latch reg_addr and txn_width.
  - txn_width=11: go to RESP with data 0.
  - Otherwise go to READ.
- Both requests in the same cycle: the write wins. The read is taken on a later cycle because reg_addr_v stays high.
- WRITE: bus_data_write_n=latched width from the cycle after the strobe until bus_data_ready=1. Then go to IDLE with strobes back to 11 on the next edge.
- READ:
  - bus_data_read_n=latched width until bus_data_ready=1.
  - Capture bus_data_in masked to width and zero-extended: byte keeps [7:0], half keeps [15:0], word keeps all bits.
  - Then go to RESP.
- RESP:
  - reg_data_i holds the captured value; reg_data_i_dv=1 for exactly this one cycle.
  - Next state is DRAIN.
- DRAIN: wait for reg_addr_v=0 before returning to IDLE. This prevents a held request from triggering a second read. reg_data_i holds its value.
- Latency:
  - Read: reg_addr_v seen in IDLE at cycle N → read strobe active from N+1.
  - Ready at cycle M → reg_data_i_dv at M+1.
  - Zero-wait peripheral (ready in the first strobe cycle): dv at N+2.
- Watchdog:
  - Counts cycles spent in WRITE or READ; clears on entry to either state.
  - On reaching TIMEOUT without ready: abort, set err_timeout.
  - Aborted write: go to IDLE.
  - Aborted read: go to RESP with data all-ones (0xFFFFFFFF).
- Ready and timeout in the same cycle: ready wins, no error.
- err_timeout:
  - Set by an abort and cleared by err_clear.
  - Abort and err_clear in the same cycle: set wins.
- bus_data_ready outside WRITE/READ is ignored.
- ena=0: everything freezes, including the watchdog. The bus strobes keep their current value.

Test Plan:
- Write word: reg_addr=0x05, reg_data_o=0x12345678, width=10, dv pulse; ready 2 cycles later → write_n=10 for exactly 3 cycles, bus_addr=0x05, bus_data_out=0x12345678, then 11.
- Read byte: reg_addr_v=1, width=00, bus_data_in=0xAABBCCDD, ready in the first strobe cycle → reg_data_i=0x000000DD, dv one cycle at N+2, no second read while reg_addr_v stays high.
- Read half, 5 wait states: bus_data_in=0x0000BEEF → read_n=01 for 6 cycles, reg_data_i=0x0000BEEF.
- Timeout, TIMEOUT=8: read, never ready → read_n released after 8 cycles, reg_data_i=0xFFFFFFFF with dv, err_timeout=1; err_clear → 0.
- Invalid width 11: a write is dropped (write_n stays 11); a read gives dv with 0 and no bus strobe.
- Reset during READ wait: rst=1 → read_n=11 and no dv; a new read after reset completes normally. Also check that ena=0 for 4 cycles mid-read stretches the latency by exactly 4.

Source files
------------

// File: rtl/spi_reg_bus_bridge.sv
// Bridges decoded SPI register transactions onto a TinyQV-style peripheral bus,
// with a watchdog that aborts unacknowledged accesses and flags a sticky error.
module spi_reg_bus_bridge #(
    parameter int ADDR_W  = 6,
    parameter int REG_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [ADDR_W-1:0] reg_addr,
    input  logic              reg_rw,
    input  logic [1:0]        txn_width,
    input  logic [REG_W-1:0]  reg_data_o,
    input  logic              reg_data_o_dv,
    input  logic              reg_addr_v,
    output logic [REG_W-1:0]  reg_data_i,
    output logic              reg_data_i_dv,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [REG_W-1:0]  bus_data_out,
    output logic [1:0]        bus_data_write_n,
    output logic [1:0]        bus_data_read_n,
    input  logic [REG_W-1:0]  bus_data_in,
    input  logic              bus_data_ready,
    output logic              err_timeout,
    input  logic              err_clear
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RESP,
        S_DRAIN
    } state_t;

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t            state, state_nx;
    logic [1:0]        width, width_nx;
    logic [7:0]        wd_cnt, wd_cnt_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [REG_W-1:0]  wdata_nx;
    logic [REG_W-1:0]  rdata_nx;
    logic [1:0]        wr_n_nx, rd_n_nx;
    logic              dv_nx;
    logic              err_nx;

    function automatic logic [REG_W-1:0] mask_width(input logic [1:0] w, input logic [REG_W-1:0] d);
        logic [REG_W-1:0] m;
        case (w)
            2'b00:   m = {{(REG_W-8){1'b0}}, d[7:0]};
            2'b01:   m = {{(REG_W-16){1'b0}}, d[15:0]};
            default: m = d;
        endcase
        return m;
    endfunction

    // Strobes are registered: the comb block computes the value they take after this edge.
    always_comb begin
        state_nx  = state;
        width_nx  = width;
        wd_cnt_nx = wd_cnt;
        addr_nx   = bus_addr;
        wdata_nx  = bus_data_out;
        rdata_nx  = reg_data_i;
        wr_n_nx   = 2'b11;
        rd_n_nx   = 2'b11;
        dv_nx     = 1'b0;
        err_nx    = err_timeout & ~err_clear;

        case (state)
            S_IDLE: begin
                if (reg_data_o_dv) begin
                    addr_nx  = reg_addr;
                    wdata_nx = reg_data_o;
                    width_nx = txn_width;
                    if (txn_width != 2'b11) begin
                        state_nx  = S_WRITE;
                        wr_n_nx   = txn_width;
                        wd_cnt_nx = '0;
                    end
                end else if (reg_addr_v && !reg_rw) begin
                    addr_nx  = reg_addr;
                    width_nx = txn_width;
                    if (txn_width == 2'b11) begin
                        state_nx = S_RESP;
                        rdata_nx = '0;
                        dv_nx    = 1'b1;
                    end else begin
                        state_nx  = S_READ;
                        rd_n_nx   = txn_width;
                        wd_cnt_nx = '0;
                    end
                end
            end
            S_WRITE: begin
                if (bus_data_ready) begin
                    state_nx = S_IDLE;
                end else if (wd_cnt == WD_LAST) begin
                    state_nx = S_IDLE;
                    err_nx   = 1'b1;
                end else begin
                    wr_n_nx   = width;
                    wd_cnt_nx = wd_cnt + 8'd1;
                end
            end
            S_READ: begin
                if (bus_data_ready) begin
                    state_nx = S_RESP;
                    rdata_nx = mask_width(width, bus_data_in);
                    dv_nx    = 1'b1;
                end else if (wd_cnt == WD_LAST) begin
                    state_nx = S_RESP;
                    rdata_nx = '1;
                    dv_nx    = 1'b1;
                    err_nx   = 1'b1;
                end else begin
                    rd_n_nx   = width;
                    wd_cnt_nx = wd_cnt + 8'd1;
                end
            end
            S_RESP: begin
                state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                if (!reg_addr_v) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            width            <= 2'b11;
            wd_cnt           <= '0;
            bus_addr         <= '0;
            bus_data_out     <= '0;
            reg_data_i       <= '0;
            reg_data_i_dv    <= 1'b0;
            bus_data_write_n <= 2'b11;
            bus_data_read_n  <= 2'b11;
            err_timeout      <= 1'b0;
        end else if (ena) begin
            state            <= state_nx;
            width            <= width_nx;
            wd_cnt           <= wd_cnt_nx;
            bus_addr         <= addr_nx;
            bus_data_out     <= wdata_nx;
            reg_data_i       <= rdata_nx;
            reg_data_i_dv    <= dv_nx;
            bus_data_write_n <= wr_n_nx;
            bus_data_read_n  <= rd_n_nx;
            err_timeout      <= err_nx;
        end
    end

endmodule

// File: tb/tb_spi_reg_bus_bridge.sv
// Self-checking bench for spi_reg_bus_bridge: directed vector table, hand-written
// reset/abort sequences and random transactions against a transaction-level model.
module tb_spi_reg_bus_bridge;

    localparam int TMO = 8;

    logic        clk;
    logic        rst;
    logic        ena;
    logic [5:0]  reg_addr;
    logic        reg_rw;
    logic [1:0]  txn_width;
    logic [31:0] reg_data_o;
    logic        reg_data_o_dv;
    logic        reg_addr_v;
    logic [31:0] reg_data_i;
    logic        reg_data_i_dv;
    logic [5:0]  bus_addr;
    logic [31:0] bus_data_out;
    logic [1:0]  bus_data_write_n;
    logic [1:0]  bus_data_read_n;
    logic [31:0] bus_data_in;
    logic        bus_data_ready;
    logic        err_timeout;
    logic        err_clear;

    int tests = 0;
    int fails = 0;

    spi_reg_bus_bridge #(
        .ADDR_W (6),
        .REG_W  (32),
        .TIMEOUT(TMO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ena             (ena),
        .reg_addr        (reg_addr),
        .reg_rw          (reg_rw),
        .txn_width       (txn_width),
        .reg_data_o      (reg_data_o),
        .reg_data_o_dv   (reg_data_o_dv),
        .reg_addr_v      (reg_addr_v),
        .reg_data_i      (reg_data_i),
        .reg_data_i_dv   (reg_data_i_dv),
        .bus_addr        (bus_addr),
        .bus_data_out    (bus_data_out),
        .bus_data_write_n(bus_data_write_n),
        .bus_data_read_n (bus_data_read_n),
        .bus_data_in     (bus_data_in),
        .bus_data_ready  (bus_data_ready),
        .err_timeout     (err_timeout),
        .err_clear       (err_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [5:0]  addr;
        logic [1:0]  width;
        logic [31:0] wdata;
        logic [31:0] bus_in;
        int          waits;      // extra wait cycles before ready; >= TMO means never
        int          gap;        // ena-low cycles inserted after the first strobe cycle
        logic        clr;        // pulse err_clear in the abort cycle
        int          exp_strobe;
        int          exp_dv;
        logic [31:0] exp_rdata;
        int          exp_lat;
        logic        exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Transaction-level reference: outcome follows from width validity and whether ready beats the watchdog.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        bit   invalid;
        bit   to;
        r       = v;
        invalid = (v.width == 2'b11);
        to      = (v.waits + 1) > TMO;
        r.exp_err    = !invalid && to;
        r.exp_strobe = invalid ? 0 : (to ? TMO : v.waits + 1);
        if (v.wr) begin
            r.exp_dv    = 0;
            r.exp_rdata = '0;
            r.exp_lat   = 0;
        end else begin
            r.exp_dv  = 1;
            r.exp_lat = invalid ? 1 : r.exp_strobe + 1 + v.gap;
            if (invalid)               r.exp_rdata = 32'h0;
            else if (to)               r.exp_rdata = 32'hFFFF_FFFF;
            else if (v.width == 2'b00) r.exp_rdata = v.bus_in % 256;
            else if (v.width == 2'b01) r.exp_rdata = v.bus_in % 65536;
            else                       r.exp_rdata = v.bus_in;
        end
        return r;
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        int          strobe, dvc, lat, wrong, drop_at;
        logic [1:0]  sval;
        logic [5:0]  aseen;
        logic [31:0] dseen, rdata;
        logic        wa, ra;
        strobe = 0; dvc = 0; lat = 0; wrong = 0; drop_at = -1;
        sval = 2'b11; aseen = '0; dseen = '0; rdata = '0;
        @(posedge clk); #1;
        reg_addr    = v.addr;
        txn_width   = v.width;
        bus_data_in = v.bus_in;
        if (v.wr) begin
            reg_rw        = 1'b1;
            reg_data_o    = v.wdata;
            reg_data_o_dv = 1'b1;
        end else begin
            reg_rw     = 1'b0;
            reg_addr_v = 1'b1;
        end
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            reg_data_o_dv  = 1'b0;
            ena            = !(v.gap > 0 && c >= 2 && c < 2 + v.gap);
            err_clear      = 1'b0;
            bus_data_ready = 1'b0;
            if (reg_data_i_dv) begin
                dvc++;
                rdata = reg_data_i;
                if (lat == 0) begin
                    lat     = c;
                    drop_at = c + 3;
                end
            end
            if (c == drop_at) reg_addr_v = 1'b0;
            wa = (bus_data_write_n != 2'b11);
            ra = (bus_data_read_n != 2'b11);
            if ((v.wr && ra) || (!v.wr && wa)) wrong++;
            if ((wa || ra) && ena) begin
                strobe++;
                sval           = v.wr ? bus_data_write_n : bus_data_read_n;
                aseen          = bus_addr;
                dseen          = bus_data_out;
                bus_data_ready = (strobe == v.waits + 1);
                if (v.clr && strobe == TMO) err_clear = 1'b1;
            end
        end
        ena        = 1'b1;
        reg_addr_v = 1'b0;
        err_clear  = 1'b0;

        check({tag, " strobe_cycles"}, strobe, v.exp_strobe);
        check({tag, " dv_count"}, dvc, v.exp_dv);
        check({tag, " wrong_strobe"}, wrong, 0);
        if (v.exp_dv > 0) begin
            check({tag, " rdata"}, rdata, v.exp_rdata);
            check({tag, " dv_latency"}, lat, v.exp_lat);
        end
        if (v.exp_strobe > 0) begin
            check({tag, " strobe_width"}, {30'd0, sval}, {30'd0, v.width});
            check({tag, " bus_addr"}, {26'd0, aseen}, {26'd0, v.addr});
            if (v.wr) check({tag, " bus_data_out"}, dseen, v.wdata);
        end
        check({tag, " err_timeout"}, {31'd0, err_timeout}, {31'd0, v.exp_err});
        if (v.exp_err) begin
            @(posedge clk); #1 err_clear = 1'b1;
            @(posedge clk); #1 err_clear = 1'b0;
            check({tag, " err_cleared"}, {31'd0, err_timeout}, 32'd0);
        end
    endtask

    vec_t table_v[12];
    vec_t rv;
    int   bad;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got hang, expected finish");
        $fatal(1);
    end

    initial begin
        //              wr    addr   w      wdata          bus_in         waits gap clr strobe dv rdata          lat err
        table_v[0]  = '{1'b1, 6'h05, 2'b10, 32'h1234_5678, 32'h0,         2,  0, 0, 3, 0, 32'h0,         0, 0};
        table_v[1]  = '{1'b0, 6'h0A, 2'b00, 32'h0,         32'hAABB_CCDD, 0,  0, 0, 1, 1, 32'h0000_00DD, 2, 0};
        table_v[2]  = '{1'b0, 6'h11, 2'b01, 32'h0,         32'h0000_BEEF, 5,  0, 0, 6, 1, 32'h0000_BEEF, 7, 0};
        table_v[3]  = '{1'b0, 6'h3F, 2'b10, 32'h0,         32'hCAFE_F00D, 3,  0, 0, 4, 1, 32'hCAFE_F00D, 5, 0};
        table_v[4]  = '{1'b1, 6'h00, 2'b00, 32'hA5A5_A5A5, 32'h0,         0,  0, 0, 1, 0, 32'h0,         0, 0};
        table_v[5]  = '{1'b1, 6'h2A, 2'b01, 32'h0000_FFFF, 32'h0,         7,  0, 0, 8, 0, 32'h0,         0, 0};
        table_v[6]  = '{1'b0, 6'h15, 2'b10, 32'h0,         32'h1122_3344, 99, 0, 0, 8, 1, 32'hFFFF_FFFF, 9, 1};
        table_v[7]  = '{1'b1, 6'h07, 2'b11, 32'h5555_5555, 32'h0,         0,  0, 0, 0, 0, 32'h0,         0, 0};
        table_v[8]  = '{1'b0, 6'h08, 2'b11, 32'h0,         32'h1234_5678, 0,  0, 0, 0, 1, 32'h0,         1, 0};
        table_v[9]  = '{1'b0, 6'h1C, 2'b10, 32'h0,         32'h8765_4321, 2,  4, 0, 3, 1, 32'h8765_4321, 8, 0};
        table_v[10] = '{1'b1, 6'h33, 2'b10, 32'h0BAD_F00D, 32'h0,         99, 0, 1, 8, 0, 32'h0,         0, 1};
        table_v[11] = '{1'b0, 6'h21, 2'b01, 32'h0,         32'h1234_BEEF, 1,  0, 0, 2, 1, 32'h0000_BEEF, 3, 0};

        rst = 1'b1; ena = 1'b1; reg_addr = '0; reg_rw = 1'b0; txn_width = 2'b00;
        reg_data_o = '0; reg_data_o_dv = 1'b0; reg_addr_v = 1'b0;
        bus_data_in = '0; bus_data_ready = 1'b0; err_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset reg_data_i", reg_data_i, 32'h0);
        check("reset reg_data_i_dv", {31'd0, reg_data_i_dv}, 32'd0);
        check("reset bus_addr", {26'd0, bus_addr}, 32'd0);
        check("reset bus_data_out", bus_data_out, 32'h0);
        check("reset write_n", {30'd0, bus_data_write_n}, 32'd3);
        check("reset read_n", {30'd0, bus_data_read_n}, 32'd3);
        check("reset err_timeout", {31'd0, err_timeout}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            run_txn(table_v[i], $sformatf("vec%0d", i));
        end

        // Reset while a read is waiting on the peripheral.
        @(posedge clk); #1;
        reg_addr = 6'h2C; txn_width = 2'b10; reg_rw = 1'b0; reg_addr_v = 1'b1;
        bus_data_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("midread read_n", {30'd0, bus_data_read_n}, 32'd2);
        rst = 1'b1; reg_addr_v = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        check("rst_midread read_n", {30'd0, bus_data_read_n}, 32'd3);
        check("rst_midread write_n", {30'd0, bus_data_write_n}, 32'd3);
        check("rst_midread dv", {31'd0, reg_data_i_dv}, 32'd0);
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (reg_data_i_dv || bus_data_read_n != 2'b11) bad++;
        end
        check("rst_midread quiet", bad, 0);
        rv = '{1'b0, 6'h19, 2'b01, 32'h0, 32'h9999_ABCD, 1, 0, 0, 0, 0, 32'h0, 0, 0};
        run_txn(model(rv), "post_rst");

        for (int i = 0; i < 30; i++) begin
            rv.wr     = 1'($urandom % 2);
            rv.addr   = 6'($urandom);
            rv.width  = 2'($urandom % 4);
            rv.wdata  = $urandom;
            rv.bus_in = $urandom;
            rv.waits  = int'($urandom_range(0, 10));
            rv.gap    = 0;
            rv.clr    = 1'b0;
            run_txn(model(rv), $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
